// File: rtl/dmem_arbiter_if.sv
// Request/response bundle for one data-memory requester port.
// The requester side uses the master modport, the arbiter side uses the slave modport.
interface dmem_arbiter_if;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;

   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_we, req_size, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_size, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port (core c / debug d) arbiter and IDLE->ISSUE->RESP sequencer for the data memory.
// Define DMEM_ARB_ROUND_ROBIN_EN for alternating grants; the default is c priority with a MAX_WAIT override.
module dmem_arbiter #(
   parameter int unsigned MEM_SIZE = 4096,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   dmem_arbiter_if.slave       c,
   dmem_arbiter_if.slave       d,
   output logic                mem_en,
   output logic                mem_we,
   output logic [1:0]          mem_size,
   output logic [31:0]         mem_addr,
   output logic [31:0]         mem_wdata,
   input  logic [31:0]         mem_rdata
);
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic                owner_q, owner_d;
   logic                err_q, err_d;
   logic                mem_en_q, mem_en_d;
   logic                mem_we_q, mem_we_d;
   logic [1:0]          mem_size_q, mem_size_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                c_rsp_valid_q, c_rsp_valid_d;
   logic                d_rsp_valid_q, d_rsp_valid_d;
   logic                c_rsp_err_q, c_rsp_err_d;
   logic                d_rsp_err_q, d_rsp_err_d;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
   logic                rr_ptr_q, rr_ptr_d;
`else
   logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
`endif

   logic                in_idle;
   logic                grant_d;
   logic                handshake;
   logic                sel_we;
   logic [1:0]          sel_size;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;
   logic [ADDR_W:0]     nbytes;
   logic                size_bad;
   logic                misalign;
   logic                oob;
   logic                req_err;
   logic                good_load;

   assign in_idle = (state_q == ST_IDLE);

   // grant_d = 1 selects port d; only meaningful while d is valid
`ifdef DMEM_ARB_ROUND_ROBIN_EN
   assign grant_d = d.req_valid & (~c.req_valid | rr_ptr_q);
`else
   assign grant_d = d.req_valid & (~c.req_valid | (wait_cnt_q >= CNT_W'(MAX_WAIT)));
`endif

   assign c.req_ready = in_idle & c.req_valid & ~grant_d;
   assign d.req_ready = in_idle & grant_d;
   assign handshake   = in_idle & (c.req_valid | d.req_valid);

   assign sel_we    = grant_d ? d.req_we    : c.req_we;
   assign sel_size  = grant_d ? d.req_size  : c.req_size;
   assign sel_addr  = grant_d ? d.req_addr  : c.req_addr;
   assign sel_wdata = grant_d ? d.req_wdata : c.req_wdata;

   // Alignment and size legality of the winning request
   always_comb begin
      nbytes   = (ADDR_W+1)'(4);
      size_bad = 1'b0;
      misalign = 1'b0;
      case (sel_size)
         2'b00:   nbytes = (ADDR_W+1)'(1);
         2'b01: begin
            nbytes   = (ADDR_W+1)'(2);
            misalign = sel_addr[0];
         end
         2'b11: begin
            nbytes   = (ADDR_W+1)'(4);
            misalign = |sel_addr[1:0];
         end
         default: size_bad = 1'b1;
      endcase
   end

   // 33-bit end address so accesses near 2^32 cannot wrap back into range
   assign oob     = ({1'b0, sel_addr} + nbytes) > (ADDR_W+1)'(MEM_SIZE);
   assign req_err = size_bad | misalign | oob;

   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      err_d         = err_q;
      mem_en_d      = 1'b0;
      mem_we_d      = mem_we_q;
      mem_size_d    = mem_size_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      c_rsp_valid_d = 1'b0;
      d_rsp_valid_d = 1'b0;
      c_rsp_err_d   = 1'b0;
      d_rsp_err_d   = 1'b0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      rr_ptr_d      = rr_ptr_q;
`else
      wait_cnt_d    = wait_cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (handshake) begin
               owner_d     = grant_d;
               err_d       = req_err;
               mem_en_d    = ~req_err;
               mem_we_d    = sel_we;
               mem_size_d  = sel_size;
               mem_addr_d  = sel_addr;
               mem_wdata_d = sel_wdata;
               state_d     = ST_ISSUE;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
               rr_ptr_d    = ~grant_d;
`else
               if (grant_d) begin
                  wait_cnt_d = '0;
               end else if (d.req_valid && (wait_cnt_q != {CNT_W{1'b1}})) begin
                  wait_cnt_d = wait_cnt_q + CNT_W'(1);
               end
`endif
            end
         end
         ST_ISSUE: begin
            c_rsp_valid_d = ~owner_q;
            d_rsp_valid_d = owner_q;
            c_rsp_err_d   = ~owner_q & err_q;
            d_rsp_err_d   = owner_q & err_q;
            state_d       = ST_RESP;
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         owner_q       <= 1'b0;
         err_q         <= 1'b0;
         mem_en_q      <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_size_q    <= 2'b00;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         c_rsp_valid_q <= 1'b0;
         d_rsp_valid_q <= 1'b0;
         c_rsp_err_q   <= 1'b0;
         d_rsp_err_q   <= 1'b0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
         rr_ptr_q      <= 1'b0;
`else
         wait_cnt_q    <= '0;
`endif
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         err_q         <= err_d;
         mem_en_q      <= mem_en_d;
         mem_we_q      <= mem_we_d;
         mem_size_q    <= mem_size_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         c_rsp_valid_q <= c_rsp_valid_d;
         d_rsp_valid_q <= d_rsp_valid_d;
         c_rsp_err_q   <= c_rsp_err_d;
         d_rsp_err_q   <= d_rsp_err_d;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
         rr_ptr_q      <= rr_ptr_d;
`else
         wait_cnt_q    <= wait_cnt_d;
`endif
      end
   end

   // Read data arrives the cycle after mem_en, i.e. in RESP, so it is steered through unregistered
   assign good_load   = ~err_q & ~mem_we_q;
   assign c.rsp_rdata = (c_rsp_valid_q & good_load) ? mem_rdata : '0;
   assign d.rsp_rdata = (d_rsp_valid_q & good_load) ? mem_rdata : '0;
   assign c.rsp_valid = c_rsp_valid_q;
   assign d.rsp_valid = d_rsp_valid_q;
   assign c.rsp_err   = c_rsp_err_q;
   assign d.rsp_err   = d_rsp_err_q;

   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_size  = mem_size_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and sequencer in front of the byte-addressed data memory. It shares the single memory port between the core load/store unit (port `c`) and the debug/program-loader port (port `d`). Each accepted request is checked for alignment and bounds, issued as a one-cycle memory enable, and answered with a one-cycle response pulse carrying read data or an error.

## Interface
- `MEM_SIZE`, default 4096: memory size in bytes, a multiple of 4; the bounds limit.
- `MAX_WAIT`, default 4: number of consecutive cycles port `d` may be refused before it is forced to win (fixed-priority mode only); range 1–15.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `c_req_valid` / `d_req_valid`  in  1  request present.
- `c_req_ready` / `d_req_ready`  out  1  request accepted this cycle.
- `c_req_we` / `d_req_we`  in  1  1 = store, 0 = load.
- `c_req_size` / `d_req_size`  in  2  00 byte, 01 halfword, 11 word, 10 illegal.
- `c_req_addr` / `d_req_addr`  in  32  byte address.
- `c_req_wdata` / `d_req_wdata`  in  32  store data, LSB-aligned.
- `c_rsp_valid` / `d_rsp_valid`  out  1  one-cycle response pulse.
- `c_rsp_rdata` / `d_rsp_rdata`  out  32  load data; 0 for stores and errors.
- `c_rsp_err` / `d_rsp_err`  out  1  misaligned, out of bounds or illegal size; valid with `rsp_valid`.
- `mem_en`  out  1  memory access strobe.
- `mem_we`  out  1  memory write enable.
- `mem_size`  out  2  size encoding passed to memory.
- `mem_addr`  out  32  registered address.
- `mem_wdata`  out  32  registered store data.
- `mem_rdata`  in  32  memory read data, valid the cycle after `mem_en`.

## Operation
- States: IDLE, ISSUE, RESP.
- **IDLE**
  - Exactly one `*_req_ready` is high, driven combinationally toward the winner. If neither port is valid, both readies are low.
  - On handshake (valid & ready), latch the request fields and the owner, then go to ISSUE.
- **Arbitration (fixed priority)**
  - `c` wins by default.
  - `wait_cnt` (4 bits) increments each IDLE cycle in which `d` is valid but `c` wins. It clears when `d` is granted.
  - When `wait_cnt` is at least `MAX_WAIT`, `d` wins.
- **Error check** (evaluated at latch):
  - size 10 is an error;
  - halfword with `addr[0]` set is an error;
  - word with `addr[1:0]` ≠ 0 is an error;
  - `addr` + nbytes > `MEM_SIZE` is an error. This comparison is done 33 bits wide, so there is no wrap-around.
- **ISSUE**
  - Without error: `mem_en` = 1 for exactly one cycle; `mem_we` = latched `we`.
  - With error: `mem_en` stays 0.
  - Always go to RESP next.
- **RESP**
  - The owner's `rsp_valid` = 1 for one cycle. `rsp_rdata` = `mem_rdata` for a good load, otherwise 0. `rsp_err` = latched error.
  - Return to IDLE.
- Responses have no backpressure. A requester must accept the pulse.
- Outputs to the non-owner port hold 0.

## Timing
- Handshake in cycle T; `mem_en` in T+1; `rsp_valid` in T+2. The next handshake is possible no earlier than T+3, giving a throughput of one access per 3 cycles.
- `mem_addr`, `mem_wdata`, `mem_size` and `mem_we` are registered. They are stable from T+1 until the next handshake.
- Reset values:
  - state IDLE;
  - `wait_cnt` 0;
  - round-robin pointer = `c`;
  - `mem_en`, `mem_we`, `mem_size`, `mem_addr`, `mem_wdata` all 0;
  - all `rsp_*` outputs 0.
- Reset asserted mid-operation: the access is abandoned and no response is produced. If `mem_en` has not yet fired, no memory write occurs.
- Both ports valid in the same cycle: the arbitration rule decides. The loser's `req_ready` stays 0 and it must hold its request stable.

## Configuration
- `DMEM_ARB_ROUND_ROBIN_EN`
  - Defined: when both ports are valid, the grant alternates. A 1-bit pointer toggles to the other port after every handshake. `wait_cnt` and `MAX_WAIT` are unused.
  - When only one port is valid, that port wins regardless of the pointer.
  - Undefined: fixed `c` priority with the `MAX_WAIT` starvation override described above.

## Test plan
- Store word, then load word: `c` issues SW addr 0x10 data 0xDEADBEEF, then LW 0x10. The load returns `c_rsp_rdata` 0xDEADBEEF with `c_rsp_err` 0. `mem_en` fires at T+1 and `rsp_valid` at T+2.
- Misaligned access: `d` issues LW addr 0x12. `d_rsp_err` = 1, rdata 0, and `mem_en` is never asserted. Also check LH at addr 0x11 → error, and size 10 → error.
- Bounds check: word access at addr 0xFFC with `MEM_SIZE` 4096 → OK; word at 0x1000 → error; word at 0xFFFFFFFC → error (no wrap).
- Contention, fixed priority, `MAX_WAIT` 4: `c` and `d` valid continuously. `c` takes 4 grants, then `d` takes the 5th; `wait_cnt` returns to 0.
- Contention with `DMEM_ARB_ROUND_ROBIN_EN`: both valid. Grants alternate c, d, c, d; with only `d` valid, `d` wins every IDLE.
- Reset mid-operation: assert `rst_n` = 0 in ISSUE of a store to 0x20. No response is produced, every output reads 0, and a subsequent load of 0x20 returns the old value.
